updown_load_reg: RTL and testbench

Parametrised successor to the team's 4-bit loadable data register: a WIDTH-bit register that can load, hold, increment by one value and decrement by another, in the same cycle if required. Sticky overflow and underflow flags, zero and max status, and a one-cycle update strobe are included. It sits on the single fast-clock domain and feeds downstream control logic that consumes `data_out` and `upd`.

---
 rtl/updown_pkg.sv | 17 +
 rtl/updown_load_reg_if.sv | 27 ++
 rtl/updown_step.sv | 30 +++
 rtl/updown_load_reg.sv | 88 ++++++++
 tb/tb_updown_load_reg.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/updown_pkg.sv
// Shared types and helpers for the up/down loadable register.
package updown_pkg;

    // Operation selected each cycle, in priority order clr > load > step > hold.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_STEP
    } op_e;

    // All-ones value of a register of the given width (width <= 63).
    function automatic logic [63:0] max_of(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/updown_load_reg_if.sv
// Control and status bundle of updown_load_reg; master drives commands, slave is the register.
interface updown_load_reg_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             clr;
    logic             next;
    logic             dec;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] decre_in;
    logic [WIDTH-1:0] data_out;
    logic             upd;
    logic             ovf;
    logic             unf;
    logic             zero;
    logic             max;

    modport master (
        output enable, clr, next, dec, data_in, decre_in,
        input  data_out, upd, ovf, unf, zero, max
    );

    modport slave (
        input  enable, clr, next, dec, data_in, decre_in,
        output data_out, upd, ovf, unf, zero, max
    );
endinterface

// File: rtl/updown_step.sv
// Combinational net add/subtract step with range detection.
// UPDOWN_SAT_EN selects saturating results; otherwise results wrap modulo 2^WIDTH.
module updown_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] inc,
    input  logic [WIDTH-1:0] decr,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf_hit,
    output logic             unf_hit
);
    // Two guard bits: one for the carry past 2^WIDTH-1, one for the sign.
    logic signed [WIDTH+1:0] r;

    always_comb begin
        r = $signed({2'b00, cur}) + $signed({2'b00, inc}) - $signed({2'b00, decr});
    end

    assign unf_hit = r[WIDTH+1];
    assign ovf_hit = ~r[WIDTH+1] & r[WIDTH];

`ifdef UPDOWN_SAT_EN
    assign nxt = ovf_hit ? {WIDTH{1'b1}} :
                 unf_hit ? {WIDTH{1'b0}} : r[WIDTH-1:0];
`else
    assign nxt = r[WIDTH-1:0];
`endif

endmodule

// File: rtl/updown_load_reg.sv
// WIDTH-bit loadable up/down register with sticky ovf/unf, zero/max status and an update strobe.
// Build option: define UPDOWN_SAT_EN for saturating arithmetic (default wraps).
module updown_load_reg
    import updown_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clock1,
    input  logic              rst_n,
    updown_load_reg_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(max_of(WIDTH));

    op_e              op;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             upd_q, upd_d;
    logic [WIDTH-1:0] inc_amt, dec_amt;
    logic [WIDTH-1:0] step_nxt;
    logic             step_ovf, step_unf;

    always_comb begin
        if (bus.clr)                     op = OP_CLR;
        else if (bus.enable)             op = OP_LOAD;
        else if (bus.next || bus.dec)    op = OP_STEP;
        else                             op = OP_HOLD;
    end

    assign inc_amt = bus.next ? bus.data_in  : '0;
    assign dec_amt = bus.dec  ? bus.decre_in : '0;

    updown_step #(.WIDTH(WIDTH)) u_step (
        .cur     (data_q),
        .inc     (inc_amt),
        .decr    (dec_amt),
        .nxt     (step_nxt),
        .ovf_hit (step_ovf),
        .unf_hit (step_unf)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data_d = data_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        unique case (op)
            OP_CLR: begin
                data_d = RST_VAL;
                ovf_d  = 1'b0;
                unf_d  = 1'b0;
            end
            OP_LOAD: data_d = bus.data_in;
            OP_STEP: begin
                data_d = step_nxt;
                ovf_d  = ovf_q | step_ovf;
                unf_d  = unf_q | step_unf;
            end
            default: ;
        endcase
        // Strobe only on an actual value change; identical loads and zero steps stay quiet.
        upd_d = (data_d != data_q);
    end

    always_ff @(posedge clock1 or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            upd_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            data_q <= data_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            upd_q  <= upd_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.upd      = upd_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
    assign bus.zero     = (data_q == '0);
    assign bus.max      = (data_q == MAX_VAL);

endmodule

// File: tb/tb_updown_load_reg.sv
// Directed, table-driven bench for updown_load_reg at WIDTH=4, RST_VAL=0 (either build).
module tb_updown_load_reg;

`ifdef UPDOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clock1 = 1'b0;
    logic rst_n  = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clock1 = ~clock1;

    updown_load_reg_if #(.WIDTH(4)) bus ();

    updown_load_reg #(.WIDTH(4), .RST_VAL(4'd0)) dut (
        .clock1 (clock1),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        bit       en, clr, nx, dc;
        bit [3:0] din, dein;
        bit [3:0] e_data;
        bit       e_upd, e_ovf, e_unf;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(bit en, bit clr, bit nx, bit dc, bit [3:0] din, bit [3:0] dein,
                                bit [3:0] e_data, bit e_upd, bit e_ovf, bit e_unf);
        vec_t v;
        v.en = en; v.clr = clr; v.nx = nx; v.dc = dc; v.din = din; v.dein = dein;
        v.e_data = e_data; v.e_upd = e_upd; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input bit en, input bit clr, input bit nx, input bit dc,
                         input bit [3:0] din, input bit [3:0] dein);
        bus.enable = en; bus.clr = clr; bus.next = nx; bus.dec = dc;
        bus.data_in = din; bus.decre_in = dein;
    endtask

    task automatic check_all(input string tag, input bit [3:0] d, input bit u, input bit o, input bit n);
        check({tag, " data_out"}, 32'(bus.data_out), 32'(d));
        check({tag, " upd"},      32'(bus.upd),      32'(u));
        check({tag, " ovf"},      32'(bus.ovf),      32'(o));
        check({tag, " unf"},      32'(bus.unf),      32'(n));
        check({tag, " zero"},     32'(bus.zero),     32'(d == 4'd0));
        check({tag, " max"},      32'(bus.max),      32'(d == 4'd15));
    endtask

    initial begin
        //                en clr nx dc din dein  data              upd         ovf unf
        vecs[0]  = mk(1, 0, 0, 0, 9,  0,   9,                1,          0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0,  0,   9,                0,          0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 14, 0,   14,               1,          0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 3,  0,   SAT ? 4'd15 : 4'd1, 1,        1, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0,  0,   0,                1,          0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 2,  0,   2,                1,          0, 0);
        vecs[6]  = mk(0, 0, 0, 1, 0,  5,   SAT ? 4'd0 : 4'd13, 1,        0, 1);
        vecs[7]  = mk(0, 1, 0, 0, 0,  0,   0,                SAT ? 1'b0 : 1'b1, 0, 0);
        vecs[8]  = mk(1, 0, 0, 0, 7,  0,   7,                1,          0, 0);
        vecs[9]  = mk(0, 0, 1, 1, 4,  4,   7,                0,          0, 0);
        vecs[10] = mk(0, 0, 1, 0, 0,  0,   7,                0,          0, 0);
        vecs[11] = mk(1, 1, 1, 0, 5,  0,   0,                1,          0, 0);
        vecs[12] = mk(1, 0, 1, 0, 3,  0,   3,                1,          0, 0);
        vecs[13] = mk(0, 0, 0, 1, 0,  3,   0,                1,          0, 0);
        vecs[14] = mk(0, 0, 1, 0, 15, 0,   15,               1,          0, 0);
        vecs[15] = mk(0, 0, 1, 0, 1,  0,   SAT ? 4'd15 : 4'd0, SAT ? 1'b0 : 1'b1, 1, 0);
        vecs[16] = mk(0, 0, 0, 1, 0,  1,   SAT ? 4'd14 : 4'd15, 1, 1, SAT ? 1'b0 : 1'b1);

        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock1);
        #1;
        check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clock1);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].nx, vecs[i].dc, vecs[i].din, vecs[i].dein);
            @(posedge clock1);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_upd, vecs[i].e_ovf, vecs[i].e_unf);
            @(negedge clock1);
        end

        // Build data_out=11 with a sticky ovf, then pull reset mid-cycle.
        drive(1, 1, 0, 0, 0, 0);
        @(posedge clock1);
        @(negedge clock1);
        drive(1, 0, 0, 0, 14, 0);
        @(posedge clock1);
        @(negedge clock1);
        drive(0, 0, 1, 0, 13, 0);
        @(posedge clock1);
        @(negedge clock1);
        drive(1, 0, 0, 0, 11, 0);
        @(posedge clock1);
        #1;
        check("pre-reset data_out", 32'(bus.data_out), 32'd11);
        check("pre-reset ovf",      32'(bus.ovf),      32'd1);
        drive(0, 0, 1, 0, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async data_out", 32'(bus.data_out), 32'd0);
        check("async ovf",      32'(bus.ovf),      32'd0);
        check("async upd",      32'(bus.upd),      32'd0);
        check("async zero",     32'(bus.zero),     32'd1);
        @(posedge clock1);
        #1;
        check("held-in-reset data_out", 32'(bus.data_out), 32'd0);

        @(negedge clock1);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 9, 0);
        @(posedge clock1);
        #1;
        check("post-reset data_out", 32'(bus.data_out), 32'd9);
        check("post-reset upd",      32'(bus.upd),      32'd1);
        @(negedge clock1);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clock1);
        #1;
        check("post-reset hold upd", 32'(bus.upd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
